instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/address width in bits.
REQ-002 Parameter DEPTH, default 1024, instruction memory depth in words (power of two).
REQ-003 Parameter BOOT_ADDR, default 32'h0, byte address of the first fetch after a load completes.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ld_start  input  1  single-cycle pulse that enters LOAD.
REQ-007 ld_valid  input  1  loader word valid.
REQ-008 ld_data  input  DATA_WIDTH  loader instruction word.
REQ-009 ld_last  input  1  marks the final loader word.
REQ-010 ld_ready  output  1  loader ready; high only in LOAD.
REQ-011 ld_count  output  $clog2(DEPTH)+1  words accepted in the current load.
REQ-012 stall  input  1  holds fetch and outputs.
REQ-013 redirect  input  1  jump request.
REQ-014 redirect_addr  input  DATA_WIDTH  jump target byte address.
REQ-015 pc_out  output  DATA_WIDTH  byte address of instr.
REQ-016 instr  output  DATA_WIDTH  fetched instruction.
REQ-017 instr_valid  output  1  instr/pc_out valid.
REQ-018 fetch_err  output  1  sticky error flag.
REQ-019 state  output  2  IDLE=00, LOAD=01, RUN=10, ERR=11.

Function
REQ-020 Memory is DEPTH x DATA_WIDTH, word-indexed by byte address [$clog2(DEPTH)+1:2], with a synchronous read of 1-cycle latency.
REQ-021 IDLE: ld_start -> LOAD; all other inputs ignored.
REQ-022 LOAD: ld_ready=1; ld_count cleared to 0 on entry; each beat with ld_valid=1 writes mem[ld_count]=ld_data and increments ld_count.
REQ-023 LOAD exit: an accepted beat with ld_last=1, or the accepted beat at ld_count=DEPTH-1, transitions to RUN on the same edge; further ld_valid beats are ignored.
REQ-024 ld_start while in LOAD is ignored; ld_start in RUN or ERR -> LOAD, instr_valid=0, fetch_err=0, ld_count=0.
REQ-025 RUN entry: the internal fetch pointer is BOOT_ADDR; the first read issues in the first RUN cycle; instr_valid=1 with pc_out=BOOT_ADDR one edge later.
REQ-026 RUN, stall=0, redirect=0: each cycle issues a read at the fetch pointer, adds 4 to the pointer, and registers instr, pc_out and instr_valid=1 at the next edge.
REQ-027 Sequential pointer increment wraps modulo DEPTH*4 (from (DEPTH-1)*4 to 0) with no error.
REQ-028 stall=1, redirect=0: no read issues, the fetch pointer holds, and instr/pc_out/instr_valid hold their values.
REQ-029 redirect=1 takes priority over stall and sets the fetch pointer to redirect_addr; the in-flight read is discarded; instr_valid=0 on the next edge; first valid output from redirect_addr appears two edges after redirect is sampled.
REQ-030 Redirect error: redirect_addr[1:0]!=0, or redirect_addr >= DEPTH*4 -> ERR on the next edge, fetch_err=1, instr_valid=0.
REQ-031 ERR: outputs are frozen except instr_valid=0; only rst or ld_start leaves ERR.
REQ-032 redirect, stall and loader inputs are ignored outside RUN and LOAD respectively.

Reset
REQ-033 On rst=1 at an edge: state=IDLE, ld_ready=0, ld_count=0, pc_out=0, instr=0, instr_valid=0, fetch_err=0, fetch pointer=BOOT_ADDR; memory contents are retained.
REQ-034 rst asserted mid-LOAD or mid-RUN aborts immediately to the REQ-033 values; a partial load is not resumed.

Verification
REQ-035 Load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 (ld_last on the 4th) -> ld_count=4, state=RUN, then pc_out 0x0,0x4,0x8,0xC with matching instr on 4 consecutive valid cycles.
REQ-036 Stall for 3 cycles after pc_out=0x4 -> pc_out=0x4 and instr held for 3 cycles, then resumes at 0x8 with no skipped or duplicated address.
REQ-037 Redirect to 0x8 while pc_out=0x0, with stall=1 on the same cycle -> next edge instr_valid=0, following edge pc_out=0x8, instr=0x002081B3.
REQ-038 Redirect to 0x6 -> state=ERR, fetch_err=1, instr_valid=0; then ld_start -> state=LOAD, fetch_err=0.
REQ-039 DEPTH=8, load 8 words without ld_last -> RUN after the 8th beat; fetch sequence 0x18,0x1C,0x0 wraps with no error.
REQ-040 rst pulse after 2 accepted load beats -> state=IDLE, ld_count=0, ld_ready=0, instr_valid=0 on the next edge.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bundles the loader, fetch-control and fetch-output signals of instr_fetch_unit.
// The master drives loader/control inputs; the slave (the fetch unit) drives status/outputs.
interface instr_fetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                  ld_start;
    logic                  ld_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;
    logic                  ld_ready;
    logic [CntW-1:0]       ld_count;
    logic                  stall;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_addr;
    logic [DATA_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  fetch_err;
    logic [1:0]            state;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, stall, redirect, redirect_addr,
        input  ld_ready, ld_count, pc_out, instr, instr_valid, fetch_err, state
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, stall, redirect, redirect_addr,
        output ld_ready, ld_count, pc_out, instr, instr_valid, fetch_err, state
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a loader fills the instruction memory, then a stallable,
// redirectable sequential fetch stream reads it with one cycle of latency.
module instr_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = 32'h0
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StErr  = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fptr_q, fptr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  fetch_en;
    logic                  redirect_bad;
    logic [AddrW-1:0]      fetch_idx;
    logic [AddrW-1:0]      fetch_idx_inc;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign fetch_idx     = fptr_q[AddrW+1:2];
    assign fetch_idx_inc = fetch_idx + AddrW'(1);
    // Misaligned or beyond the end of the memory.
    assign redirect_bad  = (bus.redirect_addr[1:0] != 2'b00) ||
                           (|bus.redirect_addr[DATA_WIDTH-1:AddrW+2]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fptr_d   = fptr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        fetch_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.ld_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (bus.ld_valid) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + CntW'(1);
                    if (bus.ld_last || (cnt_q == CntW'(DEPTH - 1))) begin
                        state_d = StRun;
                        fptr_d  = BOOT_ADDR;
                    end
                end
            end
            StRun, StErr: begin
                if (bus.ld_start) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end else if (state_q == StRun) begin
                    if (bus.redirect) begin
                        valid_d = 1'b0;
                        if (redirect_bad) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            fptr_d = bus.redirect_addr;
                        end
                    end else if (!bus.stall) begin
                        fetch_en                = 1'b1;
                        pc_d                    = fptr_q;
                        valid_d                 = 1'b1;
                        fptr_d                  = '0;
                        fptr_d[AddrW+1:0]       = {fetch_idx_inc, 2'b00};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fptr_q  <= BOOT_ADDR;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fptr_q  <= fptr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (fetch_en) begin
                instr_q <= mem_q[fetch_idx];
            end
        end
    end

    // Contents survive reset; only the write is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[cnt_q[AddrW-1:0]] <= bus.ld_data;
        end
    end

    assign bus.ld_ready    = (state_q == StLoad);
    assign bus.ld_count    = cnt_q;
    assign bus.pc_out      = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_err   = err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (DEPTH=8): a behavioural model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_instr_fetch_unit;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BOOT  = 32'h0;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_fetch_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .BOOT_ADDR (BOOT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state, in plain integers and an array.
    int          m_state = M_IDLE;
    int          m_cnt   = 0;
    int unsigned m_ptr   = 0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            m_state <= M_IDLE;
            m_cnt   <= 0;
            m_ptr   <= BOOT;
            m_pc    <= '0;
            m_instr <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_state == M_LOAD) begin
            if (bus.ld_valid) begin
                m_mem[m_cnt] <= bus.ld_data;
                m_cnt        <= m_cnt + 1;
                if (bus.ld_last || m_cnt + 1 == DEPTH) begin
                    m_state <= M_RUN;
                    m_ptr   <= BOOT;
                end
            end
        end else if (bus.ld_start) begin
            m_state <= M_LOAD;
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_state == M_RUN) begin
            if (bus.redirect) begin
                m_valid <= 1'b0;
                if ((bus.redirect_addr % 4) != 0 || bus.redirect_addr >= DEPTH * 4) begin
                    m_state <= M_ERR;
                    m_err   <= 1'b1;
                end else begin
                    m_ptr <= bus.redirect_addr;
                end
            end else if (!bus.stall) begin
                m_pc    <= m_ptr;
                m_instr <= m_mem[m_ptr / 4];
                m_valid <= 1'b1;
                m_ptr   <= (m_ptr + 4) % (DEPTH * 4);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model state",       32'(bus.state),       32'(m_state));
            check("model ld_ready",    32'(bus.ld_ready),    32'(m_state == M_LOAD));
            check("model ld_count",    32'(bus.ld_count),    32'(m_cnt));
            check("model instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            check("model fetch_err",   32'(bus.fetch_err),   32'(m_err));
            check("model pc_out",      bus.pc_out,           m_pc);
            check("model instr",       bus.instr,            m_instr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] pc, input logic [31:0] ins);
        check({name, " valid"}, 32'(bus.instr_valid), 32'd1);
        check({name, " pc"},    bus.pc_out,           pc);
        check({name, " instr"}, bus.instr,            ins);
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;
        bus.ld_start      = 1'b0;
        bus.ld_valid      = 1'b0;
        bus.ld_data       = '0;
        bus.ld_last       = 1'b0;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;

        tick();
        tick();
        chk_en = 1'b1;
        check("reset state",    32'(bus.state),       32'd0);
        check("reset ld_count", 32'(bus.ld_count),    32'd0);
        check("reset ld_ready", 32'(bus.ld_ready),    32'd0);
        check("reset valid",    32'(bus.instr_valid), 32'd0);
        check("reset pc_out",   bus.pc_out,           32'h0);
        rst = 1'b0;

        // Four-word program with ld_last on the final beat.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("enter load state", 32'(bus.state),    32'd1);
        check("enter load ready", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == 3);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("load4 state", 32'(bus.state),    32'd2);
        check("load4 count", 32'(bus.ld_count), 32'd4);
        tick();
        expect_out("fetch 0x0", 32'h0, prog[0]);
        tick();
        expect_out("fetch 0x4", 32'h4, prog[1]);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall hold", 32'h4, prog[1]);
        end
        bus.stall = 1'b0;
        tick();
        expect_out("resume 0x8", 32'h8, prog[2]);
        tick();
        expect_out("fetch 0xC", 32'hC, prog[3]);

        // Back to 0x0, then redirect to 0x8 under a simultaneous stall.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h0;
        tick();
        check("redirect bubble", 32'(bus.instr_valid), 32'd0);
        bus.redirect = 1'b0;
        tick();
        expect_out("after redirect 0x0", 32'h0, prog[0]);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h8;
        bus.stall         = 1'b1;
        tick();
        check("redirect+stall bubble", 32'(bus.instr_valid), 32'd0);
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        tick();
        expect_out("redirect target", 32'h8, 32'h002081B3);

        // Misaligned redirect goes to ERR; ld_start recovers.
        bus.stall         = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h6;
        tick();
        check("misalign state", 32'(bus.state),       32'd3);
        check("misalign err",   32'(bus.fetch_err),   32'd1);
        check("misalign valid", 32'(bus.instr_valid), 32'd0);
        bus.redirect = 1'b0;
        tick();
        check("err frozen pc", bus.pc_out, 32'h8);
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("err reload state", 32'(bus.state),     32'd1);
        check("err reload err",   32'(bus.fetch_err), 32'd0);

        // Full-depth load without ld_last; ld_start mid-load is ignored.
        for (int i = 0; i < 8; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'h10000000 + 32'(i) * 32'h11;
            bus.ld_start = (i == 2);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b0;
        check("full load state", 32'(bus.state),    32'd2);
        check("full load count", 32'(bus.ld_count), 32'd8);
        bus.stall         = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h18;
        tick();
        bus.redirect = 1'b0;
        tick();
        expect_out("wrap 0x18", 32'h18, 32'h10000066);
        tick();
        expect_out("wrap 0x1C", 32'h1C, 32'h10000077);
        tick();
        expect_out("wrap 0x0", 32'h0, 32'h10000000);
        check("wrap no err", 32'(bus.fetch_err), 32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'h00000BAD;
        tick();
        bus.ld_valid = 1'b0;
        expect_out("run ignores loader", 32'h4, 32'h10000011);
        check("run count held", 32'(bus.ld_count), 32'd8);

        // Out-of-range redirect.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h20;
        tick();
        bus.redirect = 1'b0;
        check("range state", 32'(bus.state),     32'd3);
        check("range err",   32'(bus.fetch_err), 32'd1);
        check("range pc",    bus.pc_out,         32'h4);

        // Reset after two accepted beats; those two words stay written.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD0000;
        tick();
        bus.ld_data  = 32'hDEAD0001;
        tick();
        check("partial count", 32'(bus.ld_count), 32'd2);
        rst          = 1'b1;
        bus.ld_data  = 32'hFFFFFFFF;
        tick();
        check("abort state", 32'(bus.state),       32'd0);
        check("abort count", 32'(bus.ld_count),    32'd0);
        check("abort ready", 32'(bus.ld_ready),    32'd0);
        check("abort valid", 32'(bus.instr_valid), 32'd0);
        rst          = 1'b0;
        bus.ld_valid = 1'b0;

        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hCAFE0000;
        bus.ld_last  = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("one-beat state", 32'(bus.state),    32'd2);
        check("one-beat count", 32'(bus.ld_count), 32'd1);
        tick();
        expect_out("retain 0x0", 32'h0, 32'hCAFE0000);
        tick();
        expect_out("retain 0x4", 32'h4, 32'hDEAD0001);
        tick();
        expect_out("retain 0x8", 32'h8, 32'h10000022);

        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("run reload state", 32'(bus.state),       32'd1);
        check("run reload valid", 32'(bus.instr_valid), 32'd0);
        check("run reload count", 32'(bus.ld_count),    32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
